// File: rtl/muldiv_if.sv
// muldiv_if: issue/result channel between decode/EX, writeback and muldiv_seq.
//   flush                    kill any in-flight op (mispredict/trap)
//   in_valid/in_ready        operand handshake; funct3, word, rs1, rs2, rd payload
//   out_valid/out_ready      result handshake; out_result, out_rd payload
//   busy                     unit occupied, used by hazard logic to stall issue
// master: decode/writeback side. slave: the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic            in_word;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [4:0]      in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            busy;

    modport master (
        output flush, in_valid, in_funct3, in_word, in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, busy
    );

    modport slave (
        input  flush, in_valid, in_funct3, in_word, in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M multiply/divide unit, one bit per cycle.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_if.slave: operand handshake in, result handshake out, flush, busy
// Optional feature macro MULDIV_DIV0_BYPASS_EN: divide-by-zero and signed
// overflow are resolved at accept and go straight to DONE (latency 1).
// Without it every op takes XLEN iterations.
module muldiv_seq #(
    parameter int unsigned XLEN = 64
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned SUM_W = XLEN + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0] acc_q;
    logic [XLEN-1:0]  opb_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic             word_q;
    logic             neg1_q;
    logic             neg2_q;
    logic [4:0]       rd_q;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // Operand conditioning at accept: W extension, signedness, magnitudes.
    logic            sgn1_in, sgn2_in, neg1_in, neg2_in;
    logic [XLEN-1:0] a_ext, b_ext, mag1_in, mag2_in;

    always_comb begin
        sgn1_in = !(bus.in_funct3 inside {3'b011, 3'b101, 3'b111});
        sgn2_in = bus.in_funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
        a_ext   = bus.in_rs1;
        b_ext   = bus.in_rs2;
        if (bus.in_word) begin
            // DIVUW/REMUW (funct3 odd) zero-extend, MULW/DIVW/REMW sign-extend
            a_ext = bus.in_funct3[0] ? XLEN'(bus.in_rs1[31:0]) : sext32(bus.in_rs1);
            b_ext = bus.in_funct3[0] ? XLEN'(bus.in_rs2[31:0]) : sext32(bus.in_rs2);
        end
        neg1_in = sgn1_in & a_ext[XLEN-1];
        neg2_in = sgn2_in & b_ext[XLEN-1];
        mag1_in = neg1_in ? -a_ext : a_ext;
        mag2_in = neg2_in ? -b_ext : b_ext;
    end

    // One iteration: shift-add multiply or restoring divide on {hi, lo}.
    logic [SUM_W-1:0] mul_sum, div_trial;
    logic [ACC_W-1:0] acc_nxt;

    always_comb begin
        mul_sum   = SUM_W'(acc_q[ACC_W-1:XLEN]) + (acc_q[0] ? SUM_W'(opb_q) : SUM_W'(0));
        div_trial = acc_q[ACC_W-1:XLEN-1] - SUM_W'(opb_q);
        if (f3_q[2]) begin
            acc_nxt = div_trial[XLEN] ? {acc_q[ACC_W-2:0], 1'b0}
                                      : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix and result select, taken from the final iteration's value.
    logic [ACC_W-1:0] prod;
    logic [XLEN-1:0]  quo, rem, raw_res, fix_res;

    always_comb begin
        prod    = (neg1_q ^ neg2_q) ? -acc_nxt : acc_nxt;
        quo     = (neg1_q ^ neg2_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        // divide by zero: quotient is all ones regardless of dividend sign
        if (opb_q == '0) quo = '1;
        rem     = neg1_q ? -acc_nxt[ACC_W-1:XLEN] : acc_nxt[ACC_W-1:XLEN];
        if (f3_q[2]) raw_res = f3_q[1] ? rem : quo;
        else         raw_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
        fix_res = word_q ? sext32(raw_res) : raw_res;
    end

    logic            byp_take;
    logic [XLEN-1:0] done_res;
    logic [4:0]      done_rd;

`ifdef MULDIV_DIV0_BYPASS_EN
    // Early resolution of divide-by-zero and MIN/-1 at accept.
    logic            div0_in, ovf_in;
    logic [XLEN-1:0] min_ext, byp_raw;

    always_comb begin
        min_ext  = bus.in_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div0_in  = (b_ext == '0);
        ovf_in   = sgn1_in & (a_ext == min_ext) & (b_ext == '1);
        byp_take = bus.in_funct3[2] & (div0_in | ovf_in);
        if (div0_in) byp_raw = bus.in_funct3[1] ? a_ext : '1;
        else         byp_raw = bus.in_funct3[1] ? '0 : a_ext;
        done_res = (state == IDLE) ? (bus.in_word ? sext32(byp_raw) : byp_raw) : fix_res;
        done_rd  = (state == IDLE) ? bus.in_rd : rd_q;
    end
`else
    assign byp_take = 1'b0;
    assign done_res = fix_res;
    assign done_rd  = rd_q;
`endif

    // FSM next state and control strobes.
    logic accept, done_load;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_load = 1'b0;
        case (state)
            IDLE: if (!bus.flush && bus.in_valid) state_nxt = byp_take ? DONE : BUSY;
            BUSY: begin
                if (bus.flush)                          state_nxt = IDLE;
                else if (cnt_q == CNT_W'(XLEN - 1))     state_nxt = DONE;
            end
            DONE: if (bus.flush || bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        accept    = (state == IDLE) && (state_nxt != IDLE);
        done_load = (state != DONE) && (state_nxt == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            f3_q   <= '0;
            word_q <= 1'b0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            rd_q   <= '0;
        end else if (accept) begin
            acc_q  <= {XLEN'(0), mag1_in};
            opb_q  <= mag2_in;
            cnt_q  <= '0;
            f3_q   <= bus.in_funct3;
            word_q <= bus.in_word;
            neg1_q <= neg1_in;
            neg2_q <= neg2_in;
            rd_q   <= bus.in_rd;
        end else if (state == BUSY) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_rd     <= '0;
            bus.in_ready   <= 1'b1;
            bus.busy       <= 1'b0;
        end else begin
            bus.out_valid <= (state_nxt == DONE);
            bus.in_ready  <= (state_nxt == IDLE);
            bus.busy      <= (state_nxt != IDLE);
            if (done_load) begin
                bus.out_result <= done_res;
                bus.out_rd     <= done_rd;
            end
        end
    end
endmodule
